// File: rtl/time_package.sv
// Shared time-manager types: default-width event time, its saturation value and the
// oscillator state encoding. osc_event_gen narrows/widens time via its time_bits parameter.
package time_package;
    localparam int TIME_BITS = 32;
    typedef logic [TIME_BITS-1:0] TIME_FORMAT;
    localparam TIME_FORMAT TIME_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } osc_state_t;

    // Galois feedback masks giving maximal-length sequences for the common jitter widths.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            default: return (32'h1 << (width - 1)) | 32'h1;
        endcase
    endfunction
endpackage

// File: rtl/osc_lfsr.sv
// Galois LFSR supplying the jitter term of osc_event_gen; only instantiated when
// OSC_JITTER_EN is defined. Advances once per asserted step_i, reseeds on rst.
module osc_lfsr
    import time_package::*;
#(
    parameter int              WIDTH = 4,
    parameter logic [WIDTH-1:0] SEED = 1
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             step_i,
    output logic [WIDTH-1:0] value_o
);
    localparam logic [31:0]      TAPS_W = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS   = TAPS_W[WIDTH-1:0];

    logic [WIDTH-1:0] lfsr_q;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else if (step_i) begin
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    assign value_o = lfsr_q;
endmodule

// File: rtl/osc_event_gen.sv
// Event-driven emulated clock: proposes its next toggle time to the time manager and
// toggles clk_emu when emulation time reaches it. Define OSC_JITTER_EN for LFSR jitter.
module osc_event_gen
    import time_package::*;
#(
    parameter int time_bits = 32,
    parameter int T_HI_INIT = 5,
    parameter int T_LO_INIT = 5,
    parameter int JIT_BITS  = 4
) (
    input  logic                 clk_sys,
    input  logic                 rst,
    input  logic                 en,
    input  logic [time_bits-1:0] t_hi_in,
    input  logic [time_bits-1:0] t_lo_in,
    input  logic                 period_valid,
    output logic                 period_ready,
    input  logic [time_bits-1:0] time_curr,
    output logic [time_bits-1:0] time_out,
    output logic                 clk_emu,
    output logic                 cke,
    output logic                 ovf
);
    localparam int W = time_bits;

    function automatic logic [W-1:0] nz(input logic [W-1:0] x);
        return (x == '0) ? {{(W-1){1'b0}}, 1'b1} : x;
    endfunction

    osc_state_t   state_q, state_d;
    logic         clk_emu_q, clk_emu_d;
    logic         cke_q, cke_d;
    logic         ovf_q, ovf_d;
    logic         ready_q, ready_d;
    logic [W-1:0] time_out_q, time_out_d;
    logic [W-1:0] next_evt_q, next_evt_d;
    logic [W-1:0] t_hi_q, t_hi_d, t_lo_q, t_lo_d;
    logic [W-1:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
    logic         sh_valid_q, sh_valid_d;

    logic                acc, evt;
    logic [W-1:0]        eff_hi, eff_lo, half, base;
    logic [JIT_BITS-1:0] jit_raw, jit_term;
    logic signed [W+1:0] incr_s;
    logic [W:0]          incr_u;
    logic [W+1:0]        sum;
    logic                adv_sat;
    logic [W-1:0]        adv_res;

`ifdef OSC_JITTER_EN
    osc_lfsr #(
        .WIDTH (JIT_BITS)
    ) u_lfsr (
        .clk_sys (clk_sys),
        .rst     (rst),
        .step_i  (evt),
        .value_o (jit_raw)
    );
`else
    assign jit_raw = '0;
`endif

    // A freshly accepted update takes priority, then a pending shadow, then the active value.
    assign acc    = period_valid && ready_q;
    assign evt    = (state_q != IDLE) && (time_curr == next_evt_q);
    assign eff_hi = acc ? t_hi_in : (sh_valid_q ? sh_hi_q : t_hi_q);
    assign eff_lo = acc ? t_lo_in : (sh_valid_q ? sh_lo_q : t_lo_q);

    // One saturating adder serves both RUN entry and per-event advances.
    always_comb begin
        base     = (state_q == IDLE) ? time_curr : next_evt_q;
        half     = (state_q == IDLE || clk_emu_q) ? nz(eff_lo) : nz(eff_hi);
        jit_term = evt ? jit_raw : '0;
        incr_s   = $signed({2'b00, half})
                 + $signed({{(W+2-JIT_BITS){jit_term[JIT_BITS-1]}}, jit_term});
        incr_u   = (incr_s < 1) ? {{W{1'b0}}, 1'b1} : incr_s[W:0];
        sum      = {2'b00, base} + {1'b0, incr_u};
        adv_sat  = |sum[W+1:W];
        adv_res  = adv_sat ? '1 : sum[W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        clk_emu_d  = clk_emu_q;
        cke_d      = 1'b0;
        ovf_d      = ovf_q;
        next_evt_d = next_evt_q;
        t_hi_d     = t_hi_q;
        t_lo_d     = t_lo_q;
        sh_hi_d    = sh_hi_q;
        sh_lo_d    = sh_lo_q;
        sh_valid_d = sh_valid_q;

        if (acc && !evt) begin
            if (state_q == IDLE) begin
                t_hi_d = t_hi_in;
                t_lo_d = t_lo_in;
            end else begin
                sh_hi_d    = t_hi_in;
                sh_lo_d    = t_lo_in;
                sh_valid_d = 1'b1;
            end
        end
        if (evt) begin
            t_hi_d     = eff_hi;
            t_lo_d     = eff_lo;
            sh_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d    = RUN;
                    next_evt_d = adv_res;
                    ovf_d      = ovf_q | adv_sat;
                end
            end
            RUN: begin
                if (evt) begin
                    clk_emu_d  = ~clk_emu_q;
                    cke_d      = 1'b1;
                    next_evt_d = adv_res;
                    ovf_d      = ovf_q | adv_sat;
                end
                if (!en) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (evt) begin
                    clk_emu_d = 1'b0;
                    cke_d     = clk_emu_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        time_out_d = (state_d == IDLE) ? '1 : next_evt_d;
        ready_d    = ~sh_valid_d;
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            clk_emu_q  <= 1'b0;
            cke_q      <= 1'b0;
            ovf_q      <= 1'b0;
            ready_q    <= 1'b1;
            time_out_q <= '1;
            next_evt_q <= '1;
            t_hi_q     <= W'(T_HI_INIT);
            t_lo_q     <= W'(T_LO_INIT);
            sh_hi_q    <= '0;
            sh_lo_q    <= '0;
            sh_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_emu_q  <= clk_emu_d;
            cke_q      <= cke_d;
            ovf_q      <= ovf_d;
            ready_q    <= ready_d;
            time_out_q <= time_out_d;
            next_evt_q <= next_evt_d;
            t_hi_q     <= t_hi_d;
            t_lo_q     <= t_lo_d;
            sh_hi_q    <= sh_hi_d;
            sh_lo_q    <= sh_lo_d;
            sh_valid_q <= sh_valid_d;
        end
    end

    assign period_ready = ready_q;
    assign time_out     = time_out_q;
    assign clk_emu      = clk_emu_q;
    assign cke          = cke_q;
    assign ovf          = ovf_q;
endmodule

// File: doc/osc_event_gen.md
OSC_EVENT_GEN -- requirements
Module: osc_event_gen

Interface
REQ-001 Parameter: time_bits, default 32, width of TIME_FORMAT arithmetic.
REQ-002 Parameter: T_HI_INIT, default 5, high half-period in time units after reset.
REQ-003 Parameter: T_LO_INIT, default 5, low half-period in time units after reset.
REQ-004 Parameter: JIT_BITS, default 4, jitter magnitude width (used only with OSC_JITTER_EN).
REQ-005 Port: clk_sys, in, 1, system clock; the only clock in the block.
REQ-006 Port: rst, in, 1, asynchronous active-high reset.
REQ-007 Port: en, in, 1, oscillator run request.
REQ-008 Port: t_hi_in, in, time_bits, new high half-period.
REQ-009 Port: t_lo_in, in, time_bits, new low half-period.
REQ-010 Port: period_valid, in, 1, half-period update offered.
REQ-011 Port: period_ready, out, 1, update can be accepted.
REQ-012 Port: time_curr, in, TIME_FORMAT, current emulation time from the time manager.
REQ-013 Port: time_out, out, TIME_FORMAT, proposed next event time, fed to one time_in slot of the time manager.
REQ-014 Port: clk_emu, out, 1, emulated clock level.
REQ-015 Port: cke, out, 1, one-cycle pulse for each toggle of clk_emu.
REQ-016 Port: ovf, out, 1, sticky time-overflow flag.

Function
REQ-017 States: IDLE, RUN, STOP; all outputs are registered.
REQ-018 In IDLE, time_out SHALL be TIME_MAX (all ones), so the block never wins the minimum.
REQ-019 In IDLE with en=1, the next cycle SHALL enter RUN with next_evt = time_curr + t_lo.
REQ-020 In RUN or STOP, time_out SHALL equal next_evt.
REQ-021 Event: time_curr == next_evt in RUN. clk_emu toggles and cke=1 on the following cycle. next_evt advances by t_hi if the new level is high, else by t_lo.
REQ-022 The advance SHALL be unsigned; a carry out of time_bits saturates next_evt to TIME_MAX and sets ovf.
REQ-023 In RUN with en=0, the next cycle SHALL enter STOP.
REQ-024 STOP event with clk_emu=1: clk_emu goes low, cke pulses, state becomes IDLE.
REQ-025 STOP event with clk_emu=0: no toggle, no cke, state becomes IDLE.
REQ-026 en re-asserted while in STOP SHALL have no effect until IDLE is reached.
REQ-027 Handshake: an update is accepted on period_valid && period_ready.
REQ-028 In IDLE, an accepted update SHALL write the active t_hi/t_lo directly.
REQ-029 In RUN or STOP, an accepted update SHALL go to a shadow register. period_ready is then low until the next event consumes the shadow.
REQ-030 When acceptance and an event occur in the same cycle, the event's advance SHALL use the newly accepted value.
REQ-031 A half-period of 0 SHALL be treated as 1.
REQ-032 With en=1 and an IDLE update in the same cycle, the RUN entry SHALL use the new t_lo.

Reset
REQ-033 rst asynchronously forces the following, independent of clk_sys: state=IDLE, clk_emu=0, cke=0, ovf=0, time_out=TIME_MAX, period_ready=1, t_hi=T_HI_INIT, t_lo=T_LO_INIT, shadow empty.
REQ-034 rst asserted mid-RUN SHALL discard any pending event and any shadow update.

Configuration
REQ-035 Macro OSC_JITTER_EN defined: each advance adds a signed LFSR value in [-2^(JIT_BITS-1), 2^(JIT_BITS-1)-1], and the resulting increment is clamped to at least 1.
REQ-036 Macro OSC_JITTER_EN defined: the LFSR steps once per event and reseeds to a fixed nonzero value on rst.
REQ-037 Macro OSC_JITTER_EN undefined: advances are exact and no LFSR logic exists.

Structure
REQ-038 time_package SHALL hold TIME_FORMAT, TIME_MAX and the osc_state_t enum (IDLE, RUN, STOP).
REQ-039 Sub-module osc_lfsr (Galois, JIT_BITS wide, step input) SHALL be instantiated only under OSC_JITTER_EN.

Verification
REQ-040 Scenario: reset, T_HI=5, T_LO=5, en=1 at time_curr=0, manager loop closed -> time_out sequence 5,10,15,20; clk_emu toggles 1,0,1,0; one cke per toggle.
REQ-041 Scenario: en dropped while clk_emu=1 with next_evt=30 -> clk_emu=0 at time 30, then IDLE, time_out=TIME_MAX.
REQ-042 Scenario: update t_hi=3 accepted at the same cycle as a rising event at 10 -> next_evt=13; period_ready stays 1.
REQ-043 Scenario: update offered in RUN with no event -> period_ready low until the next event, new value applied at that event.
REQ-044 Scenario: time_bits=8, next_evt=250, t_lo=10 -> next_evt=255, ovf=1 and sticky.
REQ-045 Scenario: rst pulsed asynchronously mid-RUN -> all outputs at reset values before the next clk_sys edge.
